piso_tx_scheduler: RTL and testbench
====================================

Name: piso_tx_scheduler

Overview:
Round-robin scheduler that shares one parallel-in/serial-out serializer among NUM_REQ requesters. It accepts a DATA_W-bit word from the granted requester through a valid/ready handshake. It shifts the word out LSB-first, one bit per clock, then enforces an inter-frame gap. It sits between the parallel producers and the single-wire serial link.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 4, bits per word
GAP_CYCLES, 1, idle cycles inserted after each frame (0..15)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester word valid
req_data  input  NUM_REQ*DATA_W  packed words; requester i at bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot accept strobe (combinational)
serial_out  output  1  serial data, LSB first (registered)
serial_valid  output  1  high while serial_out carries a frame bit
frame_start  output  1  one-cycle pulse with first bit of each frame
grant_id  output  $clog2(NUM_REQ)  index of requester owning the current frame
busy  output  1  high from first bit through end of gap
done  output  1  one-cycle pulse with last bit of each frame

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; serial_out, serial_valid, frame_start, busy, done = 0; grant_id = 0; RR pointer = 0; shift register and bit counter = 0. Reset mid-frame aborts the frame. No done pulse; the frame is not resumed.
- States: IDLE, SHIFT, GAP.
- IDLE: req_ready[g] = 1 only for g = first index with req_valid set, searching upward from the RR pointer with wrap. All other req_ready bits = 0. req_ready is all-zero outside IDLE.
- Handshake at edge T (valid & ready in IDLE):
  - latch the word;
  - grant_id <= g; RR pointer <= (g+1) mod NUM_REQ;
  - go to SHIFT.
- SHIFT: bit i of the word appears on serial_out in cycle T+1+i, for i = 0..DATA_W-1.
  - serial_valid = 1 for exactly DATA_W consecutive cycles.
  - frame_start = 1 in cycle T+1.
  - done = 1 in cycle T+DATA_W (last bit).
  - After the last bit, go to GAP if GAP_CYCLES > 0, else IDLE.
- GAP: GAP_CYCLES cycles with serial_valid = 0, serial_out = 0, busy = 1. Then go to IDLE.
- Earliest next handshake is at cycle T+DATA_W+GAP_CYCLES+1, so frame pitch is DATA_W+GAP_CYCLES+1 cycles.
- busy = 1 in SHIFT and GAP, 0 in IDLE. serial_out = 0 whenever serial_valid = 0.
- Requesters hold req_valid/req_data until accepted. Deasserting req_valid before acceptance is legal and loses nothing. req_data changes after acceptance do not affect the frame in flight.
- Simultaneous requests: exactly one grant per handshake. A requester left waiting is served within NUM_REQ-1 frames (starvation-free).
- No requests: the block stays in IDLE and the pointer is unchanged.
- Bit counter width is $clog2(DATA_W+2). Its maximum value never wraps.

Optional Feature:
PISO_PARITY_EN
- Defined: an even-parity bit (XOR of the DATA_W data bits) is appended after the MSB. serial_valid lasts DATA_W+1 cycles and done moves to the parity cycle. Frame pitch grows by 1.
- Undefined: no parity logic is present; behaviour is exactly as above.

Decomposition:
- Package piso_tx_pkg:
  - state typedef (IDLE/SHIFT/GAP);
  - localparam helpers for counter/ID widths;
  - default parameter constants.
- Sub-module rr_arbiter (NUM_REQ): inputs req vector, pointer, enable; outputs one-hot grant and encoded index. It is purely combinational; the pointer register stays in the parent.
- Shift register, bit counter and FSM stay in piso_tx_scheduler.

Test Plan:
- Reset, then requester 0 valid with 4'b1011, GAP_CYCLES=1 -> req_ready[0] one cycle. serial_out = 1,1,0,1 on T+1..T+4 with serial_valid high. frame_start at T+1, done at T+4, busy T+1..T+5, grant_id=0.
- All four req_valid held high with words 4'h1,4'h2,4'h3,4'h4 -> grants in order 0,1,2,3. Frames start every 6 cycles; each serial stream matches its word LSB-first.
- After a grant to 2, requesters 0 and 3 valid -> grant 3 first, then 0 (wrap).
- rst_n pulled low in cycle T+2 of a frame with 4'hF -> all outputs 0 immediately, no done pulse. After release, the pending request is re-served from pointer 0.
- GAP_CYCLES=0, two back-to-back requests -> exactly one idle (IDLE) cycle between the last bit of frame 1 and the first bit of frame 2.
- PISO_PARITY_EN defined, word 4'b0111 -> serial bits 1,1,1,0 then parity 1. serial_valid lasts 5 cycles and done is on the parity cycle.

Source files
------------

// File: rtl/piso_tx_pkg.sv
// Shared types, widths and defaults for the round-robin PISO transmit scheduler.
// PISO_PARITY_EN appends an even-parity bit to every frame.
package piso_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_W     = 4;
    localparam int DEF_GAP_CYCLES = 1;
    localparam int GAP_CNT_W      = 4;

`ifdef PISO_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int data_w);
        return $clog2(data_w + 2);
    endfunction

endpackage

// File: rtl/piso_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above the pointer, with wrap.
module rr_arbiter
    import piso_tx_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic            found;
    logic [ID_W-1:0] cand;

    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        if (enable) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = ID_W'((int'(ptr) + k) % NUM_REQ);
                if (!found && req[cand]) begin
                    found       = 1'b1;
                    grant[cand] = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

endmodule

// File: rtl/piso_tx_scheduler.sv
// Shares one LSB-first serializer among NUM_REQ requesters with round-robin grants
// and an inter-frame gap. Optional feature macro: PISO_PARITY_EN (even parity bit).
module piso_tx_scheduler
    import piso_tx_pkg::*;
#(
    parameter  int NUM_REQ    = DEF_NUM_REQ,
    parameter  int DATA_W     = DEF_DATA_W,
    parameter  int GAP_CYCLES = DEF_GAP_CYCLES,
    localparam int ID_W       = id_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      serial_out,
    output logic                      serial_valid,
    output logic                      frame_start,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic                      done
);

    localparam int CNT_W      = cnt_width(DATA_W);
    localparam int FRAME_BITS = DATA_W + PARITY_BITS;

    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0]     CNT_PEN  = CNT_W'(FRAME_BITS - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST =
        (GAP_CYCLES > 0) ? GAP_CNT_W'(GAP_CYCLES - 1) : '0;

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        ptr_q;
    logic [FRAME_BITS-1:0]  shift_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [GAP_CNT_W-1:0]   gap_cnt_q;

    logic                   arb_en;
    logic [NUM_REQ-1:0]     arb_grant;
    logic [ID_W-1:0]        arb_idx;
    logic                   accept;
    logic [DATA_W-1:0]      sel_word;
    logic [FRAME_BITS-1:0]  load_word;
    logic [ID_W-1:0]        next_ptr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .enable    (arb_en),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign req_ready = arb_grant;
    assign accept    = |arb_grant;
    assign sel_word  = req_data[int'(arb_idx)*DATA_W +: DATA_W];
    assign next_ptr  = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + ID_W'(1);

`ifdef PISO_PARITY_EN
    assign load_word = {^sel_word, sel_word};
`else
    assign load_word = sel_word;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_SHIFT;
            ST_SHIFT: if (bit_cnt_q == CNT_LAST)
                          state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            ST_GAP:   if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        arb_en       = 1'b0;
        busy         = 1'b0;
        serial_valid = 1'b0;
        case (state_q)
            ST_IDLE:  arb_en = 1'b1;
            ST_SHIFT: begin
                busy         = 1'b1;
                serial_valid = 1'b1;
            end
            ST_GAP:   busy = 1'b1;
            default:  arb_en = 1'b0;
        endcase
    end

    // Bit 0 is driven straight from the accepted word so it appears the cycle after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            grant_id    <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            serial_out  <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            done        <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        shift_q     <= load_word >> 1;
                        serial_out  <= load_word[0];
                        bit_cnt_q   <= CNT_W'(1);
                        frame_start <= 1'b1;
                        grant_id    <= arb_idx;
                        ptr_q       <= next_ptr;
                    end
                end
                ST_SHIFT: begin
                    if (bit_cnt_q != CNT_LAST) begin
                        serial_out <= shift_q[0];
                        shift_q    <= shift_q >> 1;
                        bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
                        done       <= (bit_cnt_q == CNT_PEN);
                    end else begin
                        serial_out <= 1'b0;
                        bit_cnt_q  <= '0;
                        gap_cnt_q  <= '0;
                    end
                end
                ST_GAP: gap_cnt_q <= gap_cnt_q + GAP_CNT_W'(1);
                default: serial_out <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Scoreboard bench for piso_tx_scheduler: stimulus pushes expected frames, a monitor pops and checks.
module tb_piso_tx_scheduler;
    import piso_tx_pkg::*;

    localparam int N   = 4;
    localparam int DW  = 4;
    localparam int GAP = 1;
`ifdef PISO_PARITY_EN
    localparam int FB = DW + 1;
`else
    localparam int FB = DW;
`endif
    localparam int PITCH = FB + GAP + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]         req_valid, req_ready;
    logic [N*DW-1:0]      req_data;
    logic                 serial_out, serial_valid, frame_start, busy, done;
    logic [$clog2(N)-1:0] grant_id;

    logic [N-1:0]         req_valid0, req_ready0;
    logic [N*DW-1:0]      req_data0;
    logic                 so0, sv0, fs0, busy0, done0;
    logic [$clog2(N)-1:0] gid0;

    piso_tx_scheduler #(.NUM_REQ(N), .DATA_W(DW), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .serial_out(serial_out), .serial_valid(serial_valid),
        .frame_start(frame_start), .grant_id(grant_id), .busy(busy), .done(done)
    );

    piso_tx_scheduler #(.NUM_REQ(N), .DATA_W(DW), .GAP_CYCLES(0)) dut_gap0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_data(req_data0),
        .req_ready(req_ready0), .serial_out(so0), .serial_valid(sv0),
        .frame_start(fs0), .grant_id(gid0), .busy(busy0), .done(done0)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int            id;
        logic [DW-1:0] word;
        int            pitch;
        bit            abort;
    } exp_t;

    exp_t sb[$];

    function automatic logic [7:0] exp_frame(input logic [DW-1:0] w);
        logic [7:0] f;
        f = '0;
        f[DW-1:0] = w;
`ifdef PISO_PARITY_EN
        f[DW] = ^w;
`endif
        return f;
    endfunction

    task automatic push(input int id, input logic [DW-1:0] w, input int pitch, input bit abort);
        exp_t e;
        e.id = id; e.word = w; e.pitch = pitch; e.abort = abort;
        sb.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] w);
        req_data[i*DW +: DW] = w;
        req_valid[i] = 1'b1;
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Requesters drop valid after the edge at which they were accepted.
    logic [N-1:0] hs_main, hs_gap0;
    initial forever begin
        @(negedge clk);
        hs_main = req_valid & req_ready;
        hs_gap0 = req_valid0 & req_ready0;
        @(posedge clk);
        if (rst_n) begin
            #1;
            req_valid  = req_valid & ~hs_main;
            req_valid0 = req_valid0 & ~hs_gap0;
        end
    end

    int ready_viol = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (!$onehot0(req_ready) || ((req_ready & ~req_valid) != '0) ||
                (busy && req_ready != '0))
                ready_viol++;
        end
    end

    bit mon_active = 1'b0;
    initial begin : monitor
        exp_t       e;
        logic [7:0] bits;
        int         done_cnt, done_pos, last_start;
        bit         vbad, aborted;
        last_start = 0;
        forever begin
            @(negedge clk);
            if (rst_n && frame_start) begin
                mon_active = 1'b1;
                aborted = 1'b0; bits = '0; done_cnt = 0; done_pos = -1; vbad = 1'b0;
                if (sb.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                    e.id = -1; e.word = '0; e.pitch = 0; e.abort = 1'b0;
                end else begin
                    e = sb.pop_front();
                end
                if (e.pitch != 0) check("frame_pitch", cyc - last_start, e.pitch);
                last_start = cyc;
                check("grant_id", grant_id, e.id);
                for (int i = 0; i < FB; i++) begin
                    if (i > 0) @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (!serial_valid || !busy || (i > 0 && frame_start)) vbad = 1'b1;
                    bits[i] = serial_out;
                    if (done) begin
                        done_cnt++;
                        done_pos = i;
                    end
                end
                check("frame_aborted", aborted, e.abort);
                if (!aborted) begin
                    check("frame_bits", bits, exp_frame(e.word));
                    check("frame_valid_busy", vbad, 0);
                    check("done_count", done_cnt, 1);
                    check("done_pos", done_pos, FB - 1);
                    @(negedge clk);
                    check("post_frame_line", {serial_valid, serial_out, done}, 0);
                    check("gap_busy", busy, GAP > 0);
                end else begin
                    check("abort_no_done", done_cnt, 0);
                end
                mon_active = 1'b0;
            end
        end
    end

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_valid == '0 && !busy && sb.size() == 0 && !mon_active) break;
        end
        if (i == 300) check({name, "_timeout"}, 1, 0);
    endtask

    task automatic wait_sig(input string name, input bit use_start);
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (use_start ? frame_start : busy) break;
        end
        if (i == 100) check({name, "_timeout"}, 1, 0);
    endtask

    initial begin : stimulus
        int         d1, s2, nfs, bi;
        logic [7:0] b2;
        logic [1:0] idle_line;
        req_valid = '0; req_data = '0; req_valid0 = '0; req_data0 = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {serial_out, serial_valid, frame_start, busy, done}, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_ready", req_ready, 0);
        #1 rst_n = 1'b1;

        // Single frame from requester 0, then parity-sensitive word from requester 1.
        @(posedge clk); #2; set_req(0, 4'b1011); push(0, 4'b1011, 0, 0);
        wait_idle("t1");
        @(posedge clk); #2; set_req(1, 4'b0111); push(1, 4'b0111, 0, 0);
        wait_idle("t1b");

        // Fresh pointer, all four requesting.
        @(negedge clk); #1 rst_n = 1'b0;
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #2;
        set_req(0, 4'h1); set_req(1, 4'h2); set_req(2, 4'h3); set_req(3, 4'h4);
        push(0, 4'h1, 0, 0); push(1, 4'h2, PITCH, 0);
        push(2, 4'h3, PITCH, 0); push(3, 4'h4, PITCH, 0);
        wait_idle("t2");

        // Grant to 2, then 0 and 3 wait: 3 is served before 0.
        @(posedge clk); #2; set_req(2, 4'h5); push(2, 4'h5, 0, 0);
        wait_sig("t3_busy", 1'b0);
        @(posedge clk); #2; set_req(0, 4'h6); set_req(3, 4'h9);
        push(3, 4'h9, PITCH, 0); push(0, 4'h6, PITCH, 0);
        wait_idle("t3");

        // Pointer is 1: requester 1 wins, reset aborts it, then service restarts from 0.
        @(posedge clk); #2; set_req(1, 4'hF); set_req(0, 4'h3); set_req(3, 4'hC);
        push(1, 4'hF, 0, 1); push(0, 4'h3, 0, 0); push(3, 4'hC, PITCH, 0);
        wait_sig("t4_start", 1'b1);
        @(negedge clk); #1 rst_n = 1'b0;
        #1;
        check("midrst_outputs", {serial_out, serial_valid, frame_start, busy, done}, 0);
        check("midrst_grant_id", grant_id, 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        wait_idle("t4");

        // Zero-gap instance: one idle cycle between back-to-back frames.
        @(posedge clk); #2;
        req_data0[0*DW +: DW] = 4'h5; req_data0[1*DW +: DW] = 4'hA;
        req_valid0 = 4'b0011;
        d1 = -1; s2 = -1; nfs = 0; bi = 0; b2 = '0; idle_line = 2'b11;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fs0) begin
                nfs++;
                if (nfs == 2) s2 = cyc;
            end
            if (done0 && nfs == 1) d1 = cyc;
            if (d1 >= 0 && cyc == d1 + 1) idle_line = {busy0, sv0};
            if (nfs == 2 && sv0 && bi < FB) begin
                b2[bi] = so0;
                bi++;
            end
        end
        check("gap0_frames", nfs, 2);
        check("gap0_spacing", s2 - d1, 2);
        check("gap0_idle_cycle", idle_line, 0);
        check("gap0_frame2_bits", b2, exp_frame(4'hA));
        check("gap0_grant2", gid0, 1);

        check("scoreboard_empty", sb.size(), 0);
        check("ready_protocol", ready_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
